// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one magic-memory port between I-fetch and data.
// Revision 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ROUND_ROBIN = 1,
   parameter int TIMEOUT     = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_read,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_resp,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_byte_enable,
   output logic [31:0] d_rdata,
   output logic        d_resp,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byte_enable,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp,
   output logic        busy,
   output logic        protocol_err,
   output logic        timeout_err
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               last_d_q, last_d_d;
   logic               mem_read_q, mem_read_d;
   logic               mem_write_q, mem_write_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         be_q, be_d;
   logic               perr_q, perr_d;
   logic               terr_q, terr_d;
   logic [CNT_W-1:0]   wd_q, wd_d;

   logic               w_d_req;
   logic               w_grant_d;
   logic               w_grant_i;

   // With both ports asking, D wins unless round-robin says I is owed a turn.
   assign w_d_req   = d_read | d_write;
   assign w_grant_d = w_d_req & (~i_read | (ROUND_ROBIN == 0) | ~last_d_q);
   assign w_grant_i = i_read & ~w_grant_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         be_q        <= 4'd0;
         perr_q      <= 1'b0;
         terr_q      <= 1'b0;
         wd_q        <= '0;
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         perr_q      <= perr_d;
         terr_q      <= terr_d;
         wd_q        <= wd_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      perr_d      = perr_q;
      terr_d      = terr_q;
      wd_d        = wd_q;
      case (state_q)
         IDLE: begin
            if (w_grant_d) begin
               state_d     = D_BUSY;
               last_d_d    = 1'b1;
               addr_d      = d_addr;
               wdata_d     = d_wdata;
               be_d        = d_byte_enable;
               mem_write_d = d_write;
               mem_read_d  = ~d_write;
               wd_d        = '0;
               if (d_read && d_write) begin
                  perr_d = 1'b1;
               end
            end else if (w_grant_i) begin
               state_d     = I_BUSY;
               last_d_d    = 1'b0;
               addr_d      = i_addr;
               mem_read_d  = 1'b1;
               mem_write_d = 1'b0;
               wd_d        = '0;
            end
         end
         I_BUSY, D_BUSY: begin
            if (mem_resp) begin
               state_d     = IDLE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
            end else begin
               // Watchdog only flags; the transaction keeps waiting.
               if (wd_q != CNT_W'(TIMEOUT)) begin
                  wd_d = wd_q + CNT_W'(1);
               end
               if ((TIMEOUT != 0) && (wd_q == CNT_W'(TIMEOUT - 1))) begin
                  terr_d = 1'b1;
               end
            end
         end
         default: begin
            state_d     = IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
   end

   assign mem_read        = mem_read_q;
   assign mem_write       = mem_write_q;
   assign mem_addr        = addr_q;
   assign mem_wdata       = wdata_q;
   assign mem_byte_enable = be_q;
   assign busy            = (state_q != IDLE);
   assign protocol_err    = perr_q;
   assign timeout_err     = terr_q;
   assign i_resp          = (state_q == I_BUSY) & mem_resp;
   assign d_resp          = (state_q == D_BUSY) & mem_resp;
   assign i_rdata         = mem_rdata;
   assign d_rdata         = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : randomized bench against a transaction-level model.
// Revision 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_read = 1'b0;
   logic [31:0] i_addr = '0;
   logic        d_read = 1'b0;
   logic        d_write = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_byte_enable = '0;
   logic [31:0] mem_rdata = '0;
   logic        mem_resp = 1'b0;
   logic        sel = 1'b0;

   logic        mem_resp_a, mem_resp_b;
   logic [31:0] a_i_rdata, a_d_rdata, a_addr, a_wdata, b_i_rdata, b_d_rdata, b_addr, b_wdata;
   logic [3:0]  a_be, b_be;
   logic        a_i_resp, a_d_resp, a_rd, a_wr, a_busy, a_perr, a_terr;
   logic        b_i_resp, b_d_resp, b_rd, b_wr, b_busy, b_perr, b_terr;

   logic [31:0] s_i_rdata, s_d_rdata, s_addr, s_wdata;
   logic [3:0]  s_be;
   logic        s_i_resp, s_d_resp, s_rd, s_wr, s_busy, s_perr, s_terr;

   always #5 clk = ~clk;

   assign mem_resp_a = sel ? 1'b0 : mem_resp;
   assign mem_resp_b = sel ? mem_resp : 1'b0;

   mem_port_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(8)) u_dut_a (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(a_i_rdata), .i_resp(a_i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_byte_enable(d_byte_enable), .d_rdata(a_d_rdata), .d_resp(a_d_resp),
      .mem_read(a_rd), .mem_write(a_wr), .mem_addr(a_addr), .mem_wdata(a_wdata),
      .mem_byte_enable(a_be), .mem_rdata(mem_rdata), .mem_resp(mem_resp_a),
      .busy(a_busy), .protocol_err(a_perr), .timeout_err(a_terr)
   );

   mem_port_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(0)) u_dut_b (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(b_i_rdata), .i_resp(b_i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_byte_enable(d_byte_enable), .d_rdata(b_d_rdata), .d_resp(b_d_resp),
      .mem_read(b_rd), .mem_write(b_wr), .mem_addr(b_addr), .mem_wdata(b_wdata),
      .mem_byte_enable(b_be), .mem_rdata(mem_rdata), .mem_resp(mem_resp_b),
      .busy(b_busy), .protocol_err(b_perr), .timeout_err(b_terr)
   );

   assign s_i_rdata = sel ? b_i_rdata : a_i_rdata;
   assign s_d_rdata = sel ? b_d_rdata : a_d_rdata;
   assign s_addr    = sel ? b_addr    : a_addr;
   assign s_wdata   = sel ? b_wdata   : a_wdata;
   assign s_be      = sel ? b_be      : a_be;
   assign s_i_resp  = sel ? b_i_resp  : a_i_resp;
   assign s_d_resp  = sel ? b_d_resp  : a_d_resp;
   assign s_rd      = sel ? b_rd      : a_rd;
   assign s_wr      = sel ? b_wr      : a_wr;
   assign s_busy    = sel ? b_busy    : a_busy;
   assign s_perr    = sel ? b_perr    : a_perr;
   assign s_terr    = sel ? b_terr    : a_terr;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: which port owns the memory, and what it asked for.
   bit          rr;
   int          tmo;
   bit          noresp;
   int          preq;
   int          owner;      // 0 none, 1 instruction port, 2 data port
   bit          last_d;
   logic [31:0] e_addr, e_wdata;
   logic [3:0]  e_be;
   bit          e_wr, e_perr, e_terr;
   int          wd, mwait;
   bit          i_done, d_done;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic new_d();
      int r;
      r             = $urandom_range(0, 5);
      d_read        = (r <= 2);
      d_write       = (r == 0) || (r >= 3);
      d_addr        = $urandom;
      d_wdata       = $urandom;
      d_byte_enable = 4'($urandom);
   endtask

   task automatic model_clear();
      owner  = 0;
      last_d = 0;
      e_perr = 0;
      e_terr = 0;
      wd     = 0;
      mwait  = 0;
      i_done = 0;
      d_done = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      i_read   = 1'b0;
      d_read   = 1'b0;
      d_write  = 1'b0;
      mem_resp = 1'b0;
      #1;
      chk("rst_busy", s_busy, 0);
      chk("rst_mem_read", s_rd, 0);
      chk("rst_mem_write", s_wr, 0);
      chk("rst_mem_addr", s_addr, 0);
      chk("rst_mem_wdata", s_wdata, 0);
      chk("rst_mem_be", s_be, 0);
      chk("rst_perr", s_perr, 0);
      chk("rst_terr", s_terr, 0);
      model_clear();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run(input int n);
      int win;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (i_done) begin
            i_done = 0;
            if ($urandom_range(0, 99) < preq) i_addr = $urandom;
            else i_read = 1'b0;
         end else if (!i_read && $urandom_range(0, 99) < preq) begin
            i_read = 1'b1;
            i_addr = $urandom;
         end
         if (d_done) begin
            d_done = 0;
            if ($urandom_range(0, 99) < preq) new_d();
            else begin
               d_read  = 1'b0;
               d_write = 1'b0;
            end
         end else if (!(d_read || d_write) && $urandom_range(0, 99) < preq) begin
            new_d();
         end
         // The owning requester scribbles on its inputs; the latched copy must not move.
         if (owner == 2) begin
            d_addr        = $urandom;
            d_wdata       = $urandom;
            d_byte_enable = 4'($urandom);
         end
         if (owner == 1) i_addr = $urandom;
         mem_rdata = $urandom;
         if (owner != 0) mem_resp = !noresp && (mwait == 0);
         else            mem_resp = ($urandom_range(0, 7) == 0);
         #1;
         chk("busy", s_busy, owner != 0);
         chk("mem_read", s_rd, (owner == 1) || (owner == 2 && !e_wr));
         chk("mem_write", s_wr, (owner == 2) && e_wr);
         if (owner != 0) chk("mem_addr", s_addr, e_addr);
         if (owner == 2) begin
            chk("mem_wdata", s_wdata, e_wdata);
            chk("mem_be", s_be, e_be);
         end
         chk("i_resp", s_i_resp, (owner == 1) && mem_resp);
         chk("d_resp", s_d_resp, (owner == 2) && mem_resp);
         chk("i_rdata", s_i_rdata, mem_rdata);
         chk("d_rdata", s_d_rdata, mem_rdata);
         chk("protocol_err", s_perr, e_perr);
         chk("timeout_err", s_terr, e_terr);
         if (owner != 0) begin
            if (mem_resp) begin
               if (owner == 1) i_done = 1;
               else            d_done = 1;
               owner = 0;
            end else begin
               wd++;
               if (tmo != 0 && wd == tmo) e_terr = 1;
               if (mwait > 0) mwait--;
            end
         end else begin
            win = 0;
            if (i_read && (d_read || d_write)) win = !rr ? 2 : (last_d ? 1 : 2);
            else if (i_read)                   win = 1;
            else if (d_read || d_write)        win = 2;
            if (win != 0) begin
               owner  = win;
               last_d = (win == 2);
               wd     = 0;
               mwait  = $urandom_range(0, 6);
               if (win == 1) begin
                  e_addr = i_addr;
               end else begin
                  e_addr  = d_addr;
                  e_wdata = d_wdata;
                  e_be    = d_byte_enable;
                  e_wr    = d_write;
                  if (d_read && d_write) e_perr = 1;
               end
            end
         end
      end
   endtask

   initial begin
      model_clear();
      noresp = 0;
      sel = 1'b0; rr = 1; tmo = 8;
      do_reset();
      preq = 100; run(60);
      preq = 40;  run(1500);

      sel = 1'b1; rr = 0; tmo = 0;
      do_reset();
      preq = 100; run(60);
      preq = 40;  run(1500);

      sel = 1'b0; rr = 1; tmo = 8;
      do_reset();
      noresp = 1; preq = 100; run(20);
      chk("wd_expired", s_terr, 1);
      rst = 1'b1;
      #1;
      chk("midrst_mem_read", s_rd, 0);
      chk("midrst_mem_write", s_wr, 0);
      chk("midrst_busy", s_busy, 0);
      chk("midrst_terr", s_terr, 0);
      chk("midrst_perr", s_perr, 0);
      chk("midrst_addr", s_addr, 0);
      i_read  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
      mem_resp = 1'b0;
      noresp = 0;
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      preq = 40; run(200);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
